axistream_arbiter: RTL and testbench

AXISTREAM_ARBITER -- requirements
Module: axistream_arbiter

---
 rtl/axistream_arbiter.sv | 106 ++++++++++
 tb/tb_axistream_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axistream_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream sources onto one master stream.
// Optional macro AXISTREAM_ARBITER_TID_EN adds an m_tid output that carries the granted source index.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | no grant; outputs quiet; winner chosen from the current requests
// ST_LOCKED | one source granted; beats pass through until its TLAST handshake
module axistream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast
`ifdef AXISTREAM_ARBITER_TID_EN
  ,
  output logic [$clog2(NUM_SRC)-1:0] m_tid
`endif
);

  localparam int GW = $clog2(NUM_SRC);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     winner;
  logic              locked;

  logic [DATA_W-1:0]    src_data [NUM_SRC];
  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  logic [GW:0]          start;
  logic [GW:0]          off;
  logic [GW:0]          sum;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_tdata[i*DATA_W +: DATA_W];
  end

  // Rotate the requests so the search origin (last_grant+1) lands at bit 0,
  // take the lowest set bit, then rotate the offset back into a source index.
  always_comb begin
    start   = {1'b0, last_grant} + (GW+1)'(1);
    req_dbl = {s_tvalid, s_tvalid} >> start;
    req_rot = req_dbl[NUM_SRC-1:0];
    off     = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      if (req_rot[k]) off = (GW+1)'(k);
    end
    sum = start + off;
    if (sum >= (GW+1)'(NUM_SRC)) sum = sum - (GW+1)'(NUM_SRC);
    winner = sum[GW-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_SRC-1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_tvalid) begin
            state      <= ST_LOCKED;
            grant      <= winner;
            last_grant <= winner;
          end
        end
        ST_LOCKED: begin
          if (m_tvalid && m_tready && m_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (locked) begin
      m_tvalid        = s_tvalid[grant];
      m_tdata         = src_data[grant];
      m_tlast         = s_tlast[grant];
      s_tready[grant] = m_tready;
    end
  end

`ifdef AXISTREAM_ARBITER_TID_EN
  assign m_tid = locked ? grant : '0;
`endif

endmodule

// File: tb/tb_axistream_arbiter.sv
// Self-checking bench for axistream_arbiter: directed scenarios followed by randomized traffic,
// all checked every cycle against a packet-level reference model.
module tb_axistream_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0] s_tdata;
  logic           m_tvalid, m_tready, m_tlast;
  logic [W-1:0]   m_tdata;
`ifdef AXISTREAM_ARBITER_TID_EN
  logic [1:0]     m_tid;
`endif

  axistream_arbiter #(.NUM_SRC(N), .DATA_W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
`ifdef AXISTREAM_ARBITER_TID_EN
    , .m_tid(m_tid)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner = granted source or -1, last_g = round-robin origin
  int owner, last_g, cyc;
  int len[N], beat[N], pcnt[N], pending[N], prob[N], fixlen[N];
  bit hold[N];
  int mr_mode;
  bit mr_q[$];
  int obs_src[$];
  int obs_cyc[$];
  int obs_beats;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] beat_data(int i);
    return {8'(i), 8'(pcnt[i]), 8'(beat[i]), 8'(len[i])};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_m_tdata"}, 64'(m_tdata), 64'd0);
    chk({tag, "_m_tlast"}, 64'(m_tlast), 64'd0);
`ifdef AXISTREAM_ARBITER_TID_EN
    chk({tag, "_m_tid"}, 64'(m_tid), 64'd0);
`endif
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (len[i] == 0 && pending[i] > 0) begin
        len[i]  = (fixlen[i] > 0) ? fixlen[i] : int'($urandom_range(5, 1));
        beat[i] = 0;
        pcnt[i]++;
        pending[i]--;
      end
      if (len[i] > 0) s_tvalid[i] = hold[i] || ($urandom_range(99) < prob[i]);
      else            s_tvalid[i] = 1'b0;
      s_tdata[i*W +: W] = beat_data(i);
      s_tlast[i] = (len[i] > 0) && (beat[i] == len[i] - 1);
    end
    if (mr_q.size() > 0)   m_tready = mr_q.pop_front();
    else if (mr_mode == 1) m_tready = 1'b1;
    else                   m_tready = ($urandom_range(99) < 75);
  endtask

  task automatic check_and_advance();
    logic         ev, el;
    logic [W-1:0] ed;
    logic [N-1:0] er;
    bit           hs;
    int           pick;
    #4;
    ev = 1'b0; el = 1'b0; ed = '0; er = '0;
    if (owner >= 0) begin
      ev = s_tvalid[owner];
      el = (beat[owner] == len[owner] - 1);
      ed = beat_data(owner);
      er[owner] = m_tready;
    end
    chk("m_tvalid", 64'(m_tvalid), 64'(ev));
    chk("s_tready", 64'(s_tready), 64'(er));
    if (owner < 0 || ev) begin
      chk("m_tdata", 64'(m_tdata), 64'(ed));
      chk("m_tlast", 64'(m_tlast), 64'(el));
    end
`ifdef AXISTREAM_ARBITER_TID_EN
    chk("m_tid", 64'(m_tid), (owner < 0) ? 64'd0 : 64'(owner));
`endif
    if (m_tvalid && m_tready) begin
      obs_beats++;
      if (m_tlast) begin
        pick = -1;
        for (int i = 0; i < N; i++) if (s_tready[i]) pick = i;
        obs_src.push_back(pick);
        obs_cyc.push_back(cyc);
      end
    end
    hs = (owner >= 0) && s_tvalid[owner] && m_tready;
    for (int i = 0; i < N; i++) hold[i] = s_tvalid[i] && !(hs && owner == i);
    if (owner < 0) begin
      if (|s_tvalid) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && s_tvalid[(last_g + k) % N]) pick = (last_g + k) % N;
        owner  = pick;
        last_g = pick;
      end
    end else if (hs) begin
      if (beat[owner] == len[owner] - 1) begin
        len[owner] = 0;
        owner = -1;
      end else begin
        beat[owner]++;
      end
    end
    cyc++;
    @(posedge aclk);
    #1;
  endtask

  task automatic step();
    drive();
    check_and_advance();
  endtask

  task automatic run_pkts(input int n, input int max_cyc);
    int start, c;
    start = obs_src.size();
    c = 0;
    while (obs_src.size() - start < n && c < max_cyc) begin
      step();
      c++;
    end
    chk("pkt_count", 64'(obs_src.size() - start), 64'(n));
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = '1;
    m_tready = 1'b1;
    #1;
    check_zero("rst");
    @(posedge aclk);
    #1;
    check_zero("rst_hold");
    owner  = -1;
    last_g = N - 1;
    for (int i = 0; i < N; i++) begin
      len[i]  = 0;
      hold[i] = 1'b0;
    end
    aresetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int s, c;
    for (int i = 0; i < N; i++) begin
      len[i] = 0; beat[i] = 0; pcnt[i] = 0; pending[i] = 0;
      prob[i] = 100; fixlen[i] = 3; hold[i] = 1'b0;
    end
    mr_mode = 1;
    obs_beats = 0;
    owner = -1;
    last_g = N - 1;
    cyc = 0;

    // all four sources with 3-beat packets: order 0,1,2,3 with one bubble each
    do_reset();
    for (int i = 0; i < N; i++) pending[i] = 1;
    s = obs_src.size();
    run_pkts(4, 40);
    if (obs_src.size() - s == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("A_order", 64'(obs_src[s+k]), 64'(k));
        chk("A_tlast_cycle", 64'(obs_cyc[s+k]), 64'(4*k + 3));
      end
    end

    // source 2 sends 5 beats; source 0 requests mid-packet and must wait
    fixlen[2] = 5;
    pending[2] = 1;
    c = 0;
    while (!(owner == 2 && beat[2] == 2) && c < 20) begin
      step();
      c++;
    end
    fixlen[0] = 2;
    pending[0] = 1;
    s = obs_src.size();
    run_pkts(2, 30);
    if (obs_src.size() - s == 2) begin
      chk("B_first", 64'(obs_src[s]), 64'd2);
      chk("B_second", 64'(obs_src[s+1]), 64'd0);
      chk("B_gap", 64'(obs_cyc[s+1] - obs_cyc[s]), 64'd3);
    end

    // backpressure toggling during a 4-beat packet from source 1
    fixlen[1] = 4;
    pending[1] = 1;
    for (int k = 0; k < 12; k++) mr_q.push_back(k[0] == 1'b0);
    obs_beats = 0;
    s = obs_src.size();
    run_pkts(1, 30);
    mr_q.delete();
    chk("C_beats", 64'(obs_beats), 64'd4);
    if (obs_src.size() > s) chk("C_src", 64'(obs_src[s]), 64'd1);

    // reset mid-packet: abandoned, and priority restarts from source 0
    pending[1] = 1;
    c = 0;
    while (!(owner == 1 && beat[1] == 2) && c < 20) begin
      step();
      c++;
    end
    do_reset();
    fixlen[1] = 2; fixlen[3] = 2;
    pending[1] = 1; pending[3] = 1;
    s = obs_src.size();
    run_pkts(2, 30);
    if (obs_src.size() - s == 2) begin
      chk("D_first", 64'(obs_src[s]), 64'd1);
      chk("D_second", 64'(obs_src[s+1]), 64'd3);
    end

    // single-beat packets from sources 1 and 3 alternate
    fixlen[1] = 1; fixlen[3] = 1;
    pending[1] = 6; pending[3] = 6;
    s = obs_src.size();
    run_pkts(12, 60);
    if (obs_src.size() - s == 12) begin
      chk("E_first", 64'(obs_src[s]), 64'd1);
      for (int k = 1; k < 12; k++)
        chk("E_alt", 64'(obs_src[s+k]), (obs_src[s+k-1] == 1) ? 64'd3 : 64'd1);
    end

    // randomized traffic with random validity gaps and backpressure
    for (int i = 0; i < N; i++) begin
      prob[i] = 70;
      fixlen[i] = 0;
      pending[i] = 1000;
    end
    mr_mode = 0;
    for (int k = 0; k < 3000; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
